// File: rtl/alarm_sequencer.sv
// Alarm control FSM: once-per-second setpoint compare, ringing, bounded snooze, stop and auto-timeout.
// Optional feature: define ALARM_BLINK_EN to make ring toggle on every tick while ringing.
module alarm_sequencer #(
  parameter int unsigned SNOOZE_MIN     = 9,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned MAX_SNOOZES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [7:0] cur_hr,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  input  logic [7:0] alm_hr,
  input  logic [7:0] alm_min,
  input  logic       arm,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       ring,
  output logic       armed,
  output logic       snoozing,
  output logic [3:0] snooze_cnt
);

  localparam logic [15:0] SNZ_LOAD  = 16'(SNOOZE_MIN * 60);
  localparam logic [15:0] RING_LAST = 16'(RING_TIMEOUT_S - 1);
  localparam logic [3:0]  SNZ_MAX   = 4'(MAX_SNOOZES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RINGING,
    S_SNOOZE
  } state_t;

  state_t      r_state;
  logic [15:0] r_ring_tmr;
  logic [15:0] r_snz_tmr;
  logic        r_snooze_q;
  logic        r_stop_q;

  state_t      w_state_nxt;
  logic [15:0] w_ring_tmr_nxt;
  logic [15:0] w_snz_tmr_nxt;
  logic [3:0]  w_cnt_nxt;
  logic        w_ring_nxt;
  logic        w_snooze_rise;
  logic        w_stop_rise;
  logic        w_match;

  assign w_snooze_rise = snooze_btn & ~r_snooze_q;
  assign w_stop_rise   = stop_btn & ~r_stop_q;
  // Seconds must be zero, so a stop or timeout inside the alarm minute cannot re-trigger.
  assign w_match = tick_1hz && (cur_hr == alm_hr) && (cur_min == alm_min) && (cur_sec == 8'd0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    w_state_nxt    = r_state;
    w_ring_tmr_nxt = r_ring_tmr;
    w_snz_tmr_nxt  = r_snz_tmr;
    w_cnt_nxt      = snooze_cnt;

    if (!arm) begin
      w_state_nxt    = S_IDLE;
      w_cnt_nxt      = 4'd0;
      w_ring_tmr_nxt = 16'd0;
      w_snz_tmr_nxt  = 16'd0;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_nxt = S_ARMED;
        S_ARMED: begin
          if (w_match) begin
            w_state_nxt    = S_RINGING;
            w_cnt_nxt      = 4'd0;
            w_ring_tmr_nxt = 16'd0;
          end
        end
        S_RINGING: begin
          // Priority when events coincide: stop, then snooze, then timeout.
          if (w_stop_rise) begin
            w_state_nxt = S_ARMED;
          end else if (w_snooze_rise && (snooze_cnt < SNZ_MAX)) begin
            w_state_nxt   = S_SNOOZE;
            w_cnt_nxt     = snooze_cnt + 4'd1;
            w_snz_tmr_nxt = SNZ_LOAD;
          end else if (tick_1hz && (r_ring_tmr == RING_LAST)) begin
            w_state_nxt = S_ARMED;
          end else if (tick_1hz) begin
            w_ring_tmr_nxt = r_ring_tmr + 16'd1;
          end
        end
        S_SNOOZE: begin
          if (w_stop_rise) begin
            w_state_nxt = S_ARMED;
          end else if (tick_1hz && (r_snz_tmr == 16'd1)) begin
            w_state_nxt    = S_RINGING;
            w_ring_tmr_nxt = 16'd0;
          end else if (tick_1hz) begin
            w_snz_tmr_nxt = r_snz_tmr - 16'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

`ifdef ALARM_BLINK_EN
    w_ring_nxt = 1'b0;
    if (w_state_nxt == S_RINGING) begin
      if (r_state != S_RINGING) w_ring_nxt = 1'b1;
      else if (tick_1hz)        w_ring_nxt = ~ring;
      else                      w_ring_nxt = ring;
    end
`else
    w_ring_nxt = (w_state_nxt == S_RINGING);
`endif
  end

  // Outputs are decoded from the next state, so they settle one clk after the deciding cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ring_tmr <= 16'd0;
      r_snz_tmr  <= 16'd0;
      r_snooze_q <= 1'b0;
      r_stop_q   <= 1'b0;
      ring       <= 1'b0;
      armed      <= 1'b0;
      snoozing   <= 1'b0;
      snooze_cnt <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state_nxt;
      r_ring_tmr <= w_ring_tmr_nxt;
      r_snz_tmr  <= w_snz_tmr_nxt;
      r_snooze_q <= snooze_btn;
      r_stop_q   <= stop_btn;
      ring       <= w_ring_nxt;
      armed      <= (w_state_nxt != S_IDLE);
      snoozing   <= (w_state_nxt == S_SNOOZE);
      snooze_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed vector table plus hand-written snooze/timeout/reset sequences.
module tb_alarm_sequencer;

`ifdef ALARM_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [7:0] cur_hr, cur_min, cur_sec;
  logic [7:0] alm_hr, alm_min;
  logic       arm, snooze_btn, stop_btn;
  logic       ring, armed, snoozing;
  logic [3:0] snooze_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  alarm_sequencer #(
    .SNOOZE_MIN    (1),
    .RING_TIMEOUT_S(60),
    .MAX_SNOOZES   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_1hz  (tick_1hz),
    .cur_hr    (cur_hr),
    .cur_min   (cur_min),
    .cur_sec   (cur_sec),
    .alm_hr    (alm_hr),
    .alm_min   (alm_min),
    .arm       (arm),
    .snooze_btn(snooze_btn),
    .stop_btn  (stop_btn),
    .ring      (ring),
    .armed     (armed),
    .snoozing  (snoozing),
    .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       arm, snz, stp, tk;
    logic [7:0] h, m, s;
    logic       e_ring, e_armed, e_snz;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic e_ring, e_armed, e_snz, input logic [3:0] e_cnt);
    logic [6:0] act, exp;
    act = {ring, armed, snoozing, snooze_cnt};
    exp = {e_ring, e_armed, e_snz, e_cnt};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got ring/armed/snoozing/cnt=%b/%b/%b/%0d, want %b/%b/%b/%0d",
                  name, act[6], act[5], act[4], act[3:0], exp[6], exp[5], exp[4], exp[3:0]);
  endtask

  // One clk cycle with the given inputs; returns #1 after the sampling edge.
  task automatic step(input logic a, sn, st, tk, input logic [7:0] h, m, s);
    arm = a; snooze_btn = sn; stop_btn = st; tick_1hz = tk;
    cur_hr = h; cur_min = m; cur_sec = s;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'd8, 8'd0, 8'd5);
  endtask

  // Expected ring level after k ticks spent in RINGING since entry.
  function automatic logic ring_exp(input int k);
    return BLINK ? ((k % 2) == 0) : 1'b1;
  endfunction

  initial begin
    //            arm snz stp tk  hh    mm     ss    ring armd snz cnt
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,8'd0, 8'd0, 8'd0, 1'b0,1'b0,1'b0,4'd0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,8'd0, 8'd0, 8'd0, 1'b0,1'b1,1'b0,4'd0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,8'd7, 8'd29,8'd0, 1'b0,1'b1,1'b0,4'd0};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,8'd7, 8'd30,8'd0, 1'b1,1'b1,1'b0,4'd0};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,8'd7, 8'd30,8'd0, 1'b1,1'b1,1'b0,4'd0};
    vecs[5]  = '{1'b1,1'b0,1'b1,1'b0,8'd7, 8'd30,8'd0, 1'b0,1'b1,1'b0,4'd0};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b1,8'd7, 8'd30,8'd1, 1'b0,1'b1,1'b0,4'd0};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b1,8'd7, 8'd31,8'd0, 1'b0,1'b1,1'b0,4'd0};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,8'd6, 8'd30,8'd0, 1'b0,1'b1,1'b0,4'd0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,8'd7, 8'd30,8'd0, 1'b1,1'b1,1'b0,4'd0};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b0,8'd7, 8'd30,8'd0, 1'b0,1'b1,1'b1,4'd1};
    vecs[11] = '{1'b1,1'b0,1'b1,1'b0,8'd7, 8'd30,8'd0, 1'b0,1'b1,1'b0,4'd1};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,8'd7, 8'd30,8'd0, 1'b0,1'b0,1'b0,4'd0};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1,8'd7, 8'd30,8'd0, 1'b0,1'b0,1'b0,4'd0};
    vecs[14] = '{1'b1,1'b0,1'b0,1'b1,8'd7, 8'd30,8'd0, 1'b0,1'b1,1'b0,4'd0};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b1,8'd7, 8'd30,8'd0, 1'b1,1'b1,1'b0,4'd0};
    vecs[16] = '{1'b1,1'b1,1'b1,1'b0,8'd7, 8'd30,8'd0, 1'b0,1'b1,1'b0,4'd0};
    vecs[17] = '{1'b1,1'b0,1'b0,1'b0,8'd7, 8'd30,8'd0, 1'b0,1'b1,1'b0,4'd0};

    reset = 1'b1; tick_1hz = 1'b0; arm = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    cur_hr = 8'd0; cur_min = 8'd0; cur_sec = 8'd0;
    alm_hr = 8'd7; alm_min = 8'd30;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].arm, vecs[i].snz, vecs[i].stp, vecs[i].tk, vecs[i].h, vecs[i].m, vecs[i].s);
      check($sformatf("vec%0d", i), vecs[i].e_ring, vecs[i].e_armed, vecs[i].e_snz, vecs[i].e_cnt);
    end

    // Three full snooze cycles, then a refused fourth snooze and a timeout.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 8'd30, 8'd0);
    check("seqA_ring", 1'b1, 1'b1, 1'b0, 4'd0);
    for (int n = 1; n <= 3; n++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'd8, 8'd0, 8'd5);
      check($sformatf("seqA_snooze%0d", n), 1'b0, 1'b1, 1'b1, 4'(n));
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'd8, 8'd0, 8'd5);
      if (n == 1) begin
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'd8, 8'd0, 8'd5);
        check("seqA_snooze_in_snooze", 1'b0, 1'b1, 1'b1, 4'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd8, 8'd0, 8'd5);
      end
      ticks(59);
      check($sformatf("seqA_snz%0d_59", n), 1'b0, 1'b1, 1'b1, 4'(n));
      ticks(1);
      check($sformatf("seqA_snz%0d_60", n), 1'b1, 1'b1, 1'b0, 4'(n));
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd8, 8'd0, 8'd5);
    check("seqA_snooze4_refused", 1'b1, 1'b1, 1'b0, 4'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd8, 8'd0, 8'd5);
    ticks(1);
    check("seqA_ring_t1", ring_exp(1), 1'b1, 1'b0, 4'd3);
    ticks(1);
    check("seqA_ring_t2", ring_exp(2), 1'b1, 1'b0, 4'd3);
    ticks(57);
    check("seqA_ring_t59", ring_exp(59), 1'b1, 1'b0, 4'd3);
    ticks(1);
    check("seqA_timeout", 1'b0, 1'b1, 1'b0, 4'd3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 8'd30, 8'd1);
    check("seqA_no_retrigger", 1'b0, 1'b1, 1'b0, 4'd3);

    // Timeout tick coinciding with a snooze rise, then stop+snooze with a nonzero count.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 8'd30, 8'd0);
    check("seqB_ring_cnt_clear", 1'b1, 1'b1, 1'b0, 4'd0);
    ticks(59);
    check("seqB_t59", ring_exp(59), 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd8, 8'd0, 8'd5);
    check("seqB_timeout_vs_snooze", 1'b0, 1'b1, 1'b1, 4'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd8, 8'd0, 8'd5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 8'd30, 8'd0);
    check("seqB_match_in_snooze", 1'b0, 1'b1, 1'b1, 4'd1);
    ticks(59);
    check("seqB_rering", 1'b1, 1'b1, 1'b0, 4'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'd8, 8'd0, 8'd5);
    check("seqB_stop_and_snooze", 1'b0, 1'b1, 1'b0, 4'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd8, 8'd0, 8'd5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 8'd30, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd8, 8'd0, 8'd5);
    check("seqB_snooze_again", 1'b0, 1'b1, 1'b1, 4'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'd8, 8'd0, 8'd5);
    check("seqB_stop_in_snooze", 1'b0, 1'b1, 1'b0, 4'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 8'd30, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd8, 8'd0, 8'd5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd8, 8'd0, 8'd5);
    check("seqB_disarm_in_snooze", 1'b0, 1'b0, 1'b0, 4'd0);

    // Asynchronous reset while ringing.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd8, 8'd0, 8'd5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 8'd30, 8'd0);
    check("seqC_ringing", 1'b1, 1'b1, 1'b0, 4'd0);
    #2 reset = 1'b1;
    #1 check("seqC_reset_async", 1'b0, 1'b0, 1'b0, 4'd0);
    arm = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 8'd30, 8'd0);
    check("seqC_idle_after", 1'b0, 1'b0, 1'b0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
